nor_resp_checker: RTL and testbench
===================================

NOR_RESP_CHECKER -- requirements
Module: nor_resp_checker

Interface
REQ-001 Parameter ERR_W, default 8, sets the error counter width; legal range is 4 to 16.
REQ-002 clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 start, input, 1 bit: one-cycle pulse that begins a check run.
REQ-005 in_valid, input, 1 bit: high when in_abcd and in_nor hold one applied vector and its observed response.
REQ-006 in_abcd, input, 4 bits: stimulus applied to the 4-input NOR under test; a is bit 3, d is bit 0.
REQ-007 in_nor, input, 1 bit: observed output of the NOR under test.
REQ-008 busy, output, 1 bit: high while in RUN.
REQ-009 done, output, 1 bit: one-cycle pulse on entry to DONE.
REQ-010 pass, output, 1 bit: high in DONE when err_count is zero.
REQ-011 err_count, output, ERR_W bits: count of mismatching vectors.
REQ-012 vec_count, output, 5 bits: count of accepted vectors in the current run.
REQ-013 first_err_vec, output, 4 bits: in_abcd value of the first mismatch; zero if no mismatch has occurred.
REQ-014 cov_map, output, 16 bits: bit n is set once pattern n has been accepted.

Function
REQ-015 The FSM shall have three states: IDLE, RUN and DONE.
REQ-016 IDLE shall move to RUN on start; entering RUN shall clear err_count, vec_count, first_err_vec, cov_map and pass.
REQ-017 In RUN, each cycle with in_valid high shall accept one vector.
- Expected response = NOR of the four in_abcd bits.
- A mismatch is in_nor != expected.
REQ-018 An accepted vector shall update all outputs on the next rising edge: vec_count +1, cov_map bit set, err_count +1 on mismatch; latency is one cycle.
REQ-019 err_count shall saturate at its all-ones value and shall not wrap.
REQ-020 first_err_vec shall capture only the first mismatch of a run; later mismatches shall not change it.
REQ-021 vec_count shall saturate at 31.
REQ-022 RUN shall move to DONE on the edge that accepts the completing vector (completion rule in Configuration); that vector is included in all counts.
REQ-023 done shall pulse high for exactly the first cycle in DONE.
REQ-024 pass shall be set on entry to DONE when err_count (including the completing vector) is zero.
REQ-025 DONE shall hold all outputs stable until start, which restarts as in REQ-016.
REQ-026 start while in RUN shall restart the run: counters clear, and any vector valid in the same cycle is discarded.
REQ-027 in_valid shall be ignored in IDLE and DONE.
REQ-028 Repeated patterns shall be counted in vec_count and checked for errors; they shall not change cov_map beyond the first occurrence.

Reset
REQ-029 While rst_n is low, the state shall be IDLE and every output and counter shall be zero, regardless of clk.
REQ-030 Assertion of rst_n mid-run shall abandon the run with no done pulse.
REQ-031 The first start after rst_n deasserts shall behave as REQ-016.

Configuration
REQ-032 With macro NOR_CHK_COVERAGE_EN defined, a run shall complete when cov_map becomes all ones; repeats do not complete it.
REQ-033 Without NOR_CHK_COVERAGE_EN, a run shall complete on the 16th accepted vector regardless of cov_map; cov_map shall still be maintained.

Verification
REQ-034 Reset then start, then patterns 0..15 in ascending order with a correct NOR response -> done pulses after vector 15; pass=1; err_count=0; vec_count=16; cov_map=FFFF.
REQ-035 Same sequence with in_nor inverted for patterns 5 and 9 -> err_count=2; first_err_vec=5; pass=0.
REQ-036 With the macro defined, send pattern 3 twice, then the other 15 patterns -> done follows the 17th vector; vec_count=17. Without the macro -> done follows the 16th vector; cov_map bit for the missing pattern is 0.
REQ-037 ERR_W=4 with every response wrong for 20 vectors (macro undefined, restarting as needed) -> err_count holds at 15 and does not wrap.
REQ-038 Pull rst_n low after 7 vectors -> all outputs go to 0 immediately; no done pulse; a new start runs cleanly.
REQ-039 Issue start during RUN in the same cycle as in_valid -> that vector is discarded; vec_count=0 on the next cycle.

Source files
------------

// File: rtl/nor_resp_checker.sv
// Self-checking harness for an external 4-input NOR: compares observed responses against the
// expected NOR and tracks errors and pattern coverage. Optional NOR_CHK_COVERAGE_EN: completion on full coverage.
module nor_resp_checker #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       in_abcd,
    input  logic             in_nor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [4:0]       vec_count,
    output logic [3:0]       first_err_vec,
    output logic [15:0]      cov_map
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // RUN   | accepting vectors, counters live
    // DONE  | run complete, results held until start
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    state_t      state, state_nxt;
    logic        accept;
    logic        mismatch;
    logic        complete;
    logic [15:0] cov_nxt;

    // start has priority: a vector presented alongside a restart is dropped
    assign accept   = (state == RUN) && in_valid && !start;
    assign mismatch = (in_nor != ~|in_abcd);
    assign cov_nxt  = cov_map | (16'd1 << in_abcd);
    assign busy     = (state == RUN);

`ifdef NOR_CHK_COVERAGE_EN
    assign complete = accept && (cov_nxt == 16'hFFFF);
`else
    assign complete = accept && (vec_count == 5'd15);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (start) state_nxt = RUN;
                     else if (complete) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            vec_count     <= '0;
            first_err_vec <= '0;
            cov_map       <= '0;
        end else if (start) begin
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            vec_count     <= '0;
            first_err_vec <= '0;
            cov_map       <= '0;
        end else begin
            done <= complete;
            if (accept) begin
                cov_map <= cov_nxt;
                if (vec_count != 5'd31) vec_count <= vec_count + 5'd1;
                // err_count never returns to zero within a run, so it doubles as "error seen"
                if (mismatch) begin
                    if (err_count == '0)     first_err_vec <= in_abcd;
                    if (err_count != ERR_MAX) err_count    <= err_count + ERR_ONE;
                end
            end
            if (complete) pass <= (err_count == '0) && !mismatch;
        end
    end

endmodule

// File: tb/tb_nor_resp_checker.sv
// Randomized self-checking bench for nor_resp_checker; the reference model keeps the list of
// accepted vectors of the current run and derives every expected output from that list.
module tb_nor_resp_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_abcd = 4'd0;
    logic        in_nor = 1'b0;

    logic        busy, done, pass;
    logic [7:0]  err_count;
    logic [4:0]  vec_count;
    logic [3:0]  first_err_vec;
    logic [15:0] cov_map;

    logic        busy4, done4, pass4;
    logic [3:0]  err4;
    logic [4:0]  vec4;
    logic [3:0]  first4;
    logic [15:0] cov4;

    int checks = 0;
    int errors = 0;

    nor_resp_checker #(.ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_abcd(in_abcd),
        .in_nor(in_nor), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .vec_count(vec_count), .first_err_vec(first_err_vec), .cov_map(cov_map)
    );

    nor_resp_checker #(.ERR_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_abcd(in_abcd),
        .in_nor(in_nor), .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
        .vec_count(vec4), .first_err_vec(first4), .cov_map(cov4)
    );

    always #5 clk = ~clk;

    // reference model: vectors accepted in the current run and run status
    int q_abcd[$];
    bit q_bad[$];
    bit m_running = 1'b0;
    bit m_finished = 1'b0;
    bit m_done = 1'b0;

    function automatic logic [15:0] m_cov();
        logic [15:0] c = '0;
        foreach (q_abcd[i]) c[q_abcd[i]] = 1'b1;
        return c;
    endfunction

    function automatic int m_mis();
        int n = 0;
        foreach (q_bad[i]) n += q_bad[i];
        return n;
    endfunction

    function automatic int m_err(int maxv);
        return (m_mis() > maxv) ? maxv : m_mis();
    endfunction

    function automatic int m_vec();
        return (q_abcd.size() > 31) ? 31 : q_abcd.size();
    endfunction

    function automatic int m_first();
        foreach (q_bad[i]) if (q_bad[i]) return q_abcd[i];
        return 0;
    endfunction

    function automatic bit m_pass();
        return m_finished && (m_mis() == 0);
    endfunction

    function automatic bit m_complete();
`ifdef NOR_CHK_COVERAGE_EN
        return m_cov() == 16'hFFFF;
`else
        return q_abcd.size() == 16;
`endif
    endfunction

    task automatic model_reset();
        q_abcd.delete();
        q_bad.delete();
        m_running = 1'b0;
        m_finished = 1'b0;
        m_done = 1'b0;
    endtask

    // drive one cycle of inputs, then advance the model past the rising edge
    task automatic step(input bit st, input bit v, input logic [3:0] a, input bit nr);
        @(negedge clk);
        start = st; in_valid = v; in_abcd = a; in_nor = nr;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        if (st) begin
            q_abcd.delete();
            q_bad.delete();
            m_running = 1'b1;
            m_finished = 1'b0;
        end else if (m_running && v) begin
            q_abcd.push_back(int'(a));
            q_bad.push_back(nr != (a == 4'd0));
            if (m_complete()) begin
                m_running = 1'b0;
                m_finished = 1'b1;
                m_done = 1'b1;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #13;
        checks++;
        if ({busy, done, pass, err_count, vec_count, first_err_vec, cov_map} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%b err=%0d vec=%0d first=%0d cov=%h, need all zero",
                     busy, done, pass, err_count, vec_count, first_err_vec, cov_map);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 4'd0, 1'b1);
        checks++;
        if (busy !== 1'b0 || vec_count !== 5'd0) begin
            errors++;
            $display("FAIL idle_ignores_valid: got busy=%b vec=%0d, need 0 0", busy, vec_count);
        end
    endtask

    task automatic run_ascending(input logic [15:0] flips, output int done_at);
        done_at = 0;
        step(1'b1, 1'b0, 4'd0, 1'b0);
        for (int p = 0; p < 16; p++) begin
            logic [3:0] a = 4'(p);
            step(1'b0, 1'b1, a, (a == 4'd0) ^ flips[p]);
            if (done === 1'b1 && done_at == 0) done_at = p + 1;
        end
    endtask

    task automatic test_all_correct();
        int done_at;
        run_ascending(16'h0000, done_at);
        checks++;
        if (done_at != 16 || pass !== 1'b1 || err_count !== 8'd0 || vec_count !== 5'd16 || cov_map !== 16'hFFFF) begin
            errors++;
            $display("FAIL all_correct: got done_at=%0d pass=%b err=%0d vec=%0d cov=%h, need 16 1 0 16 ffff",
                     done_at, pass, err_count, vec_count, cov_map);
        end
        step(1'b0, 1'b1, 4'd7, 1'b1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || vec_count !== 5'd16 || err_count !== 8'd0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: got done=%b busy=%b vec=%0d err=%0d pass=%b, need 0 0 16 0 1",
                     done, busy, vec_count, err_count, pass);
        end
    endtask

    task automatic test_two_errors();
        int done_at;
        run_ascending(16'h0220, done_at);
        checks++;
        if (done_at != 16 || err_count !== 8'd2 || first_err_vec !== 4'd5 || pass !== 1'b0) begin
            errors++;
            $display("FAIL two_errors: got done_at=%0d err=%0d first=%0d pass=%b, need 16 2 5 0",
                     done_at, err_count, first_err_vec, pass);
        end
    endtask

    task automatic test_repeat();
        int seq[$];
        int done_at = 0;
        int n = 0;
        seq.push_back(3);
        seq.push_back(3);
        for (int p = 0; p < 16; p++) if (p != 3) seq.push_back(p);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        foreach (seq[i]) begin
            logic [3:0] a = 4'(seq[i]);
            step(1'b0, 1'b1, a, a == 4'd0);
            n++;
            checks++;
            if (done !== m_done) begin
                errors++;
                $display("FAIL repeat_done: vector %0d got done=%b, need %b", n, done, m_done);
            end
            if (done === 1'b1 && done_at == 0) done_at = n;
        end
`ifdef NOR_CHK_COVERAGE_EN
        checks++;
        if (done_at != 17 || vec_count !== 5'd17 || cov_map !== 16'hFFFF) begin
            errors++;
            $display("FAIL repeat_cov: got done_at=%0d vec=%0d cov=%h, need 17 17 ffff", done_at, vec_count, cov_map);
        end
`else
        checks++;
        if (done_at != 16 || vec_count !== 5'd16 || cov_map !== 16'h7FFF) begin
            errors++;
            $display("FAIL repeat_count: got done_at=%0d vec=%0d cov=%h, need 16 16 7fff", done_at, vec_count, cov_map);
        end
`endif
    endtask

    task automatic test_saturate();
        int perm[16];
        for (int i = 0; i < 16; i++) perm[i] = i;
        perm.shuffle();
        step(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a = 4'(perm[i]);
            step(1'b0, 1'b1, a, a != 4'd0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'($urandom_range(15)), 1'b1);
        checks++;
        if (err4 !== 4'(m_err(15)) || err4 !== 4'd15 || err_count !== 8'(m_err(255))) begin
            errors++;
            $display("FAIL err_saturate: got err4=%0d err8=%0d, need %0d %0d", err4, err_count, m_err(15), m_err(255));
        end
        checks++;
        if (first4 !== 4'(perm[0]) || pass4 !== 1'b0) begin
            errors++;
            $display("FAIL sat_first: got first=%0d pass=%b, need %0d 0", first4, pass4, perm[0]);
        end
    endtask

    task automatic test_mid_reset();
        bit saw_done = 1'b0;
        int perm[16];
        step(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'($urandom_range(15)), 1'($urandom_range(1)));
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, err_count, vec_count, first_err_vec, cov_map} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b err=%0d vec=%0d first=%0d cov=%h, need all zero",
                     busy, err_count, vec_count, first_err_vec, cov_map);
        end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'd1, 1'b0);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL mid_reset_done: got a done pulse, need none");
        end
        for (int i = 0; i < 16; i++) perm[i] = i;
        perm.shuffle();
        step(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(perm[i]), perm[i] == 0);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || vec_count !== 5'd16 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_run: got done=%b pass=%b vec=%0d err=%0d, need 1 1 16 0",
                     done, pass, vec_count, err_count);
        end
    endtask

    task automatic test_restart();
        step(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd2, 1'b1);
        step(1'b1, 1'b1, 4'd6, 1'b1);
        checks++;
        if (vec_count !== 5'd0 || err_count !== 8'd0 || cov_map !== 16'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_discard: got vec=%0d err=%0d cov=%h busy=%b, need 0 0 0000 1",
                     vec_count, err_count, cov_map, busy);
        end
        step(1'b0, 1'b1, 4'd0, 1'b0);
        checks++;
        if (vec_count !== 5'd1 || err_count !== 8'd1 || first_err_vec !== 4'd0 || cov_map !== 16'h0001) begin
            errors++;
            $display("FAIL restart_first: got vec=%0d err=%0d first=%0d cov=%h, need 1 1 0 0001",
                     vec_count, err_count, first_err_vec, cov_map);
        end
    endtask

    task automatic test_random();
        for (int run = 0; run < 6; run++) begin
            step(1'b1, 1'b0, 4'd0, 1'b0);
            for (int cyc = 0; cyc < 200; cyc++) begin
                bit v = ($urandom_range(3) != 0);
                bit st = ($urandom_range(60) == 0);
                logic [3:0] a = 4'($urandom_range(15));
                bit nr = (a == 4'd0) ^ ($urandom_range(7) == 0);
                step(st, v, a, nr);
                checks++;
                if (done !== m_done || busy !== m_running || pass !== m_pass() ||
                    vec_count !== 5'(m_vec()) || err_count !== 8'(m_err(255)) || err4 !== 4'(m_err(15)) ||
                    first_err_vec !== 4'(m_first()) || cov_map !== m_cov()) begin
                    errors++;
                    $display("FAIL random_run%0d_cyc%0d: got done=%b busy=%b pass=%b vec=%0d err=%0d err4=%0d first=%0d cov=%h, need %b %b %b %0d %0d %0d %0d %h",
                             run, cyc, done, busy, pass, vec_count, err_count, err4, first_err_vec, cov_map,
                             m_done, m_running, m_pass(), m_vec(), m_err(255), m_err(15), m_first(), m_cov());
                end
                if (m_finished) break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_correct();
        test_two_errors();
        test_repeat();
        test_saturate();
        test_mid_reset();
        test_restart();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
